iiitb_gray_cntr_param: RTL and testbench

Parametrised up/down Gray-code counter, the next generation of the team's 4-bit Gray counter. It keeps a binary count and its Gray encoding in registers. Both always show the same count in the same cycle. It adds count enable, direction control, a parallel load in Gray code and a registered terminal-count flag. It is for pointer generation and position encoding wherever a Gray sequence with single-bit changes is needed.

---
 rtl/iiitb_gray_cntr_param.sv | 73 +++++++
 tb/tb_iiitb_gray_cntr_param.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_gray_cntr_param.sv
// Parametrised up/down Gray-code counter with registered binary/Gray outputs,
// parallel Gray load and terminal-count flag. Define IIITB_GRAY_SAT_EN for saturating mode.
module iiitb_gray_cntr_param #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_value,
  output logic [WIDTH-1:0] gray_count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] step_bin;
  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_tc;
  logic             at_limit;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // at_limit: the requested step would cross the wrap boundary
  always_comb begin
    at_limit  = up_dn ? (bin_value == MAX_VAL) : (bin_value == '0);
    step_bin  = up_dn ? (bin_value + ONE) : (bin_value - ONE);
    next_bin  = bin_value;
    next_gray = gray_count;
    next_tc   = 1'b0;
    if (load) begin
      next_bin  = gray_to_bin(load_gray);
      next_gray = load_gray;
    end else if (en) begin
`ifdef IIITB_GRAY_SAT_EN
      if (at_limit) begin
        next_tc = 1'b1;
      end else begin
        next_bin = step_bin;
      end
`else
      next_bin = step_bin;
      next_tc  = at_limit;
`endif
      // Gray derived from the new binary value so both outputs move together
      next_gray = next_bin ^ (next_bin >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_value  <= '0;
      gray_count <= '0;
      tc         <= 1'b0;
    end else begin
      bin_value  <= next_bin;
      gray_count <= next_gray;
      tc         <= next_tc;
    end
  end

endmodule

// File: tb/tb_iiitb_gray_cntr_param.sv
// Directed bench for iiitb_gray_cntr_param (WIDTH = 4), wrap or saturating build.
module tb_iiitb_gray_cntr_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_gray;
  logic [3:0] bin_value;
  logic [3:0] gray_count;
  logic       tc;

  int errors = 0;
  int checks = 0;

  logic [3:0] gray_tbl [16];
  logic [3:0] prev_bin;
  logic [3:0] prev_gray;
  logic       prev_valid = 1'b0;

  iiitb_gray_cntr_param #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up_dn      (up_dn),
    .load       (load),
    .load_gray  (load_gray),
    .bin_value  (bin_value),
    .gray_count (gray_count),
    .tc         (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Continuous invariant: Gray matches binary, and count steps flip one Gray bit
  always @(negedge clk) begin
    checks++;
    if (gray_count !== (bin_value ^ (bin_value >> 1))) begin
      errors++;
      $display("FAIL gray_consistency: gray=%b bin=%b", gray_count, bin_value);
    end
    if (prev_valid && ((bin_value == prev_bin + 4'd1) || (bin_value == prev_bin - 4'd1))) begin
      checks++;
      if ($countones(gray_count ^ prev_gray) != 1) begin
        errors++;
        $display("FAIL gray_single_bit: prev=%b now=%b", prev_gray, gray_count);
      end
    end
    prev_bin   = bin_value;
    prev_gray  = gray_count;
    prev_valid = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_gray = 4'b0000;
    #3;
    checks++;
    if ({bin_value, gray_count, tc} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: bin=%b gray=%b tc=%b expected all zero", bin_value, gray_count, tc);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_free_run();
    logic [3:0] exp_bin;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      exp_bin = 4'((i + 1) % 16);
      checks++;
      if (bin_value !== exp_bin || gray_count !== gray_tbl[exp_bin] || tc !== (exp_bin == 4'd0)) begin
        errors++;
        $display("FAIL free_run[%0d]: bin=%b gray=%b tc=%b expected bin=%b gray=%b tc=%b",
                 i, bin_value, gray_count, tc, exp_bin, gray_tbl[exp_bin], exp_bin == 4'd0);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    load = 1'b1; load_gray = 4'b0001;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    step();
    checks++;
    if (bin_value !== 4'd0 || gray_count !== 4'b0000 || tc !== 1'b0) begin
      errors++;
      $display("FAIL down_to_zero: bin=%b gray=%b tc=%b expected 0000/0000/0", bin_value, gray_count, tc);
    end
    step();
`ifdef IIITB_GRAY_SAT_EN
    checks++;
    if (bin_value !== 4'd0 || gray_count !== 4'b0000 || tc !== 1'b1) begin
      errors++;
      $display("FAIL down_sat_hold: bin=%b gray=%b tc=%b expected 0000/0000/1", bin_value, gray_count, tc);
    end
`else
    checks++;
    if (bin_value !== 4'd15 || gray_count !== 4'b1000 || tc !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: bin=%b gray=%b tc=%b expected 1111/1000/1", bin_value, gray_count, tc);
    end
    step();
    checks++;
    if (bin_value !== 4'd14 || gray_count !== 4'b1001 || tc !== 1'b0) begin
      errors++;
      $display("FAIL down_after_wrap: bin=%b gray=%b tc=%b expected 1110/1001/0", bin_value, gray_count, tc);
    end
`endif
    en = 1'b0;
  endtask

  task automatic test_load_over_en();
    load = 1'b1; load_gray = 4'b1101; en = 1'b1; up_dn = 1'b1;
    step();
    checks++;
    if (bin_value !== 4'd9 || gray_count !== 4'b1101 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_over_en: bin=%b gray=%b tc=%b expected 1001/1101/0", bin_value, gray_count, tc);
    end
    load = 1'b0;
    step();
    checks++;
    if (bin_value !== 4'd10 || gray_count !== 4'b1111 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_then_count: bin=%b gray=%b tc=%b expected 1010/1111/0", bin_value, gray_count, tc);
    end
    en = 1'b0;
  endtask

  task automatic test_hold_dir();
    load = 1'b1; load_gray = 4'b0000;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (bin_value !== 4'd5 || gray_count !== 4'b0111) begin
      errors++;
      $display("FAIL count_to_5: bin=%b gray=%b expected 0101/0111", bin_value, gray_count);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bin_value !== 4'd5 || gray_count !== 4'b0111 || tc !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: bin=%b gray=%b tc=%b expected 0101/0111/0", i, bin_value, gray_count, tc);
      end
    end
    en = 1'b1; up_dn = 1'b0;
    step();
    checks++;
    if (bin_value !== 4'd4 || gray_count !== 4'b0110) begin
      errors++;
      $display("FAIL dir_change: bin=%b gray=%b expected 0100/0110", bin_value, gray_count);
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bin_value !== 4'd7 || gray_count !== 4'b0100) begin
      errors++;
      $display("FAIL count_to_7: bin=%b gray=%b expected 0111/0100", bin_value, gray_count);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bin_value, gray_count, tc} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset: bin=%b gray=%b tc=%b expected all zero before edge", bin_value, gray_count, tc);
    end
    step();
    checks++;
    if ({bin_value, gray_count, tc} !== 9'b0) begin
      errors++;
      $display("FAIL reset_held: bin=%b gray=%b tc=%b expected all zero", bin_value, gray_count, tc);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bin_value !== 4'd1 || gray_count !== 4'b0001) begin
      errors++;
      $display("FAIL reset_release: bin=%b gray=%b expected 0001/0001", bin_value, gray_count);
    end
    en = 1'b0;
  endtask

`ifdef IIITB_GRAY_SAT_EN
  task automatic test_saturate();
    load = 1'b1; load_gray = 4'b1011;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step();
    step();
    checks++;
    if (bin_value !== 4'd15 || gray_count !== 4'b1000 || tc !== 1'b0) begin
      errors++;
      $display("FAIL sat_reach_max: bin=%b gray=%b tc=%b expected 1111/1000/0", bin_value, gray_count, tc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bin_value !== 4'd15 || gray_count !== 4'b1000 || tc !== 1'b1) begin
        errors++;
        $display("FAIL sat_hold[%0d]: bin=%b gray=%b tc=%b expected 1111/1000/1", i, bin_value, gray_count, tc);
      end
    end
    en = 1'b0;
    step();
    checks++;
    if (bin_value !== 4'd15 || gray_count !== 4'b1000 || tc !== 1'b0) begin
      errors++;
      $display("FAIL sat_en_drop: bin=%b gray=%b tc=%b expected 1111/1000/0", bin_value, gray_count, tc);
    end
  endtask
`endif

  initial begin
    gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    test_reset();
`ifndef IIITB_GRAY_SAT_EN
    test_free_run();
`endif
    test_down_wrap();
    test_load_over_en();
    test_hold_dir();
    test_async_reset();
`ifdef IIITB_GRAY_SAT_EN
    test_saturate();
`endif
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
